// File: rtl/pipe_skid_if.sv
// Handshake bundle for one pipeline stage: upstream valid/ready/beat in,
// downstream head entry out.
interface pipe_skid_if #(
   parameter int PAYLOAD_WIDTH = 64,
   parameter int SIDE_WIDTH    = 30
);
   logic                     up_valid_i;
   logic                     up_ready_o;
   logic [SIDE_WIDTH-1:0]    up_side_i;
   logic [PAYLOAD_WIDTH-1:0] up_payload_i;
   logic                     dn_valid_o;
   logic                     dn_ready_i;
   logic [SIDE_WIDTH-1:0]    dn_side_o;
   logic [PAYLOAD_WIDTH-1:0] dn_payload_o;
   logic                     dn_killed_o;
   logic [1:0]               occupancy_o;

   modport master (
      output up_valid_i, up_side_i, up_payload_i, dn_ready_i,
      input  up_ready_o, dn_valid_o, dn_side_o, dn_payload_o, dn_killed_o, occupancy_o
   );

   modport slave (
      input  up_valid_i, up_side_i, up_payload_i, dn_ready_i,
      output up_ready_o, dn_valid_o, dn_side_o, dn_payload_o, dn_killed_o, occupancy_o
   );
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid,
// synchronous flush and per-beat kill (payload -> NOP, side field kept).
//
// state | meaning
// EMPTY | no entry held, up_ready_o=1
// ONE   | head in main register, up_ready_o=1
// TWO   | head in main, second beat in skid, up_ready_o=0
module pipe_skid_reg #(
   parameter int                       PAYLOAD_WIDTH = 64,
   parameter int                       SIDE_WIDTH    = 30,
   parameter logic [PAYLOAD_WIDTH-1:0] NOP_VALUE     = '0,
   parameter bit                       SKID_EN       = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        flush_i,
   input  logic        kill_i,
   pipe_skid_if.slave  bus
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   logic                     up_ready;
   logic                     dn_valid;
   logic                     dn_killed;
   logic [SIDE_WIDTH-1:0]    dn_side;
   logic [PAYLOAD_WIDTH-1:0] dn_payload;
   logic [1:0]               occ;
   logic                     accept;
   logic                     pop;
   logic [PAYLOAD_WIDTH-1:0] in_payload;

   assign accept     = bus.up_valid_i & up_ready;
   assign pop        = dn_valid & bus.dn_ready_i;
   assign in_payload = kill_i ? NOP_VALUE : bus.up_payload_i;

   assign bus.up_ready_o   = up_ready;
   assign bus.dn_valid_o   = dn_valid;
   assign bus.dn_side_o    = dn_side;
   assign bus.dn_payload_o = dn_payload;
   assign bus.dn_killed_o  = dn_killed;
   assign bus.occupancy_o  = occ;

   generate
      if (SKID_EN) begin : g_skid
         state_t                   state;
         logic [SIDE_WIDTH-1:0]    skid_side;
         logic [PAYLOAD_WIDTH-1:0] skid_payload;
         logic                     skid_killed;

         // up_ready is a flop so downstream back-pressure never chains combinationally upstream
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               state        <= EMPTY;
               up_ready     <= 1'b1;
               dn_valid     <= 1'b0;
               dn_side      <= '0;
               dn_payload   <= NOP_VALUE;
               dn_killed    <= 1'b0;
               occ          <= 2'd0;
               skid_side    <= '0;
               skid_payload <= NOP_VALUE;
               skid_killed  <= 1'b0;
            end else if (flush_i) begin
               state        <= EMPTY;
               up_ready     <= 1'b1;
               dn_valid     <= 1'b0;
               dn_side      <= '0;
               dn_payload   <= NOP_VALUE;
               dn_killed    <= 1'b0;
               occ          <= 2'd0;
               skid_side    <= '0;
               skid_payload <= NOP_VALUE;
               skid_killed  <= 1'b0;
            end else begin
               case (state)
                  EMPTY: begin
                     if (accept) begin
                        dn_side    <= bus.up_side_i;
                        dn_payload <= in_payload;
                        dn_killed  <= kill_i;
                        dn_valid   <= 1'b1;
                        occ        <= 2'd1;
                        state      <= ONE;
                     end
                  end
                  ONE: begin
                     if (accept && !pop) begin
                        skid_side    <= bus.up_side_i;
                        skid_payload <= in_payload;
                        skid_killed  <= kill_i;
                        up_ready     <= 1'b0;
                        occ          <= 2'd2;
                        state        <= TWO;
                     end else if (accept && pop) begin
                        dn_side    <= bus.up_side_i;
                        dn_payload <= in_payload;
                        dn_killed  <= kill_i;
                     end else if (pop) begin
                        dn_valid   <= 1'b0;
                        dn_side    <= '0;
                        dn_payload <= NOP_VALUE;
                        dn_killed  <= 1'b0;
                        occ        <= 2'd0;
                        state      <= EMPTY;
                     end
                  end
                  TWO: begin
                     if (pop) begin
                        dn_side      <= skid_side;
                        dn_payload   <= skid_payload;
                        dn_killed    <= skid_killed;
                        skid_side    <= '0;
                        skid_payload <= NOP_VALUE;
                        skid_killed  <= 1'b0;
                        up_ready     <= 1'b1;
                        occ          <= 2'd1;
                        state        <= ONE;
                     end
                  end
                  default: begin
                     state    <= EMPTY;
                     up_ready <= 1'b1;
                     dn_valid <= 1'b0;
                     occ      <= 2'd0;
                  end
               endcase
            end
         end
      end else begin : g_single
         // single entry: a pop frees the slot in the same cycle, so ready looks at dn_ready
         assign up_ready = !dn_valid | bus.dn_ready_i;

         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               dn_valid   <= 1'b0;
               dn_side    <= '0;
               dn_payload <= NOP_VALUE;
               dn_killed  <= 1'b0;
               occ        <= 2'd0;
            end else if (flush_i) begin
               dn_valid   <= 1'b0;
               dn_side    <= '0;
               dn_payload <= NOP_VALUE;
               dn_killed  <= 1'b0;
               occ        <= 2'd0;
            end else if (accept) begin
               dn_valid   <= 1'b1;
               dn_side    <= bus.up_side_i;
               dn_payload <= in_payload;
               dn_killed  <= kill_i;
               occ        <= 2'd1;
            end else if (pop) begin
               dn_valid   <= 1'b0;
               dn_side    <= '0;
               dn_payload <= NOP_VALUE;
               dn_killed  <= 1'b0;
               occ        <= 2'd0;
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Drives one skid-enabled and one single-entry stage with the same directed
// stimulus; a queue model of each stage is compared every cycle.
module tb_pipe_skid_reg;
   localparam int PW = 64;
   localparam int SW = 30;
   localparam logic [PW-1:0] NOP = 64'h0000_0000_0000_0013;

   typedef struct packed {
      logic [SW-1:0] side;
      logic [PW-1:0] pl;
      logic          k;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0, kill = 1'b0, up_valid = 1'b0, dn_ready = 1'b0;
   logic [SW-1:0] up_side = '0;
   logic [PW-1:0] up_payload = '0;

   int checks = 0;
   int errors = 0;

   ent_t q_s[$];
   ent_t q_n[$];

   always #5 clk = ~clk;

   pipe_skid_if #(.PAYLOAD_WIDTH(PW), .SIDE_WIDTH(SW)) bus_s ();
   pipe_skid_if #(.PAYLOAD_WIDTH(PW), .SIDE_WIDTH(SW)) bus_n ();

   assign bus_s.up_valid_i   = up_valid;
   assign bus_s.up_side_i    = up_side;
   assign bus_s.up_payload_i = up_payload;
   assign bus_s.dn_ready_i   = dn_ready;
   assign bus_n.up_valid_i   = up_valid;
   assign bus_n.up_side_i    = up_side;
   assign bus_n.up_payload_i = up_payload;
   assign bus_n.dn_ready_i   = dn_ready;

   pipe_skid_reg #(.PAYLOAD_WIDTH(PW), .SIDE_WIDTH(SW), .NOP_VALUE(NOP), .SKID_EN(1'b1)) u_skid (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .kill_i(kill), .bus(bus_s)
   );
   pipe_skid_reg #(.PAYLOAD_WIDTH(PW), .SIDE_WIDTH(SW), .NOP_VALUE(NOP), .SKID_EN(1'b0)) u_single (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .kill_i(kill), .bus(bus_n)
   );

   // Model: a FIFO of capacity 2 (skid) or 1 (single, freed by a same-cycle pop)
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_s.delete();
         q_n.delete();
      end else begin
         ent_t e;
         bit acc_s, acc_n, pop_s, pop_n;
         e     = '{side: up_side, pl: (kill ? NOP : up_payload), k: kill};
         acc_s = up_valid && (q_s.size() < 2);
         acc_n = up_valid && (q_n.size() == 0 || dn_ready);
         pop_s = (q_s.size() > 0) && dn_ready;
         pop_n = (q_n.size() > 0) && dn_ready;
         if (flush) begin
            q_s.delete();
            q_n.delete();
         end else begin
            if (pop_s) void'(q_s.pop_front());
            if (acc_s) q_s.push_back(e);
            if (pop_n) void'(q_n.pop_front());
            if (acc_n) q_n.push_back(e);
         end
      end
   end

   task automatic chk(string nm, logic [PW-1:0] act, logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
      end
   endtask

   task automatic chk_dut(string nm, int size, ent_t h, logic exp_rdy, logic rdy,
                          logic v, logic [1:0] occ, logic [SW-1:0] side,
                          logic [PW-1:0] pl, logic k);
      chk({nm, ".up_ready"}, PW'(rdy), PW'(exp_rdy));
      chk({nm, ".dn_valid"}, PW'(v), PW'(size > 0));
      chk({nm, ".occupancy"}, PW'(occ), PW'(size));
      if (size > 0) begin
         chk({nm, ".dn_side"}, PW'(side), PW'(h.side));
         chk({nm, ".dn_payload"}, pl, h.pl);
         chk({nm, ".dn_killed"}, PW'(k), PW'(h.k));
      end
   endtask

   always begin
      @(negedge clk);
      #3;
      if (rst_n) begin
         ent_t hs, hn;
         hs = (q_s.size() > 0) ? q_s[0] : '0;
         hn = (q_n.size() > 0) ? q_n[0] : '0;
         chk_dut("skid", q_s.size(), hs, q_s.size() < 2, bus_s.up_ready_o, bus_s.dn_valid_o,
                 bus_s.occupancy_o, bus_s.dn_side_o, bus_s.dn_payload_o, bus_s.dn_killed_o);
         chk_dut("single", q_n.size(), hn, (q_n.size() == 0) || dn_ready, bus_n.up_ready_o,
                 bus_n.dn_valid_o, bus_n.occupancy_o, bus_n.dn_side_o, bus_n.dn_payload_o,
                 bus_n.dn_killed_o);
      end
   end

   task automatic cyc(logic v, logic [SW-1:0] s, logic [PW-1:0] p, logic k, logic f, logic r);
      @(negedge clk);
      #1;
      up_valid = v; up_side = s; up_payload = p; kill = k; flush = f; dn_ready = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(string nm);
      chk({nm, ".s_valid"}, PW'(bus_s.dn_valid_o), '0);
      chk({nm, ".s_occ"}, PW'(bus_s.occupancy_o), '0);
      chk({nm, ".s_payload"}, bus_s.dn_payload_o, NOP);
      chk({nm, ".s_side"}, PW'(bus_s.dn_side_o), '0);
      chk({nm, ".s_killed"}, PW'(bus_s.dn_killed_o), '0);
      chk({nm, ".n_valid"}, PW'(bus_n.dn_valid_o), '0);
      chk({nm, ".n_payload"}, bus_n.dn_payload_o, NOP);
   endtask

   initial begin
      #12 rst_n = 1'b1;
      #1;
      chk_reset_vals("reset");
      chk("reset.s_ready", PW'(bus_s.up_ready_o), 64'd1);

      // streaming
      cyc(1, 30'h11, 64'h1, 0, 0, 1); tick;
      chk("stream0", bus_s.dn_payload_o, 64'h1);
      cyc(1, 30'h12, 64'h2, 0, 0, 1); tick;
      chk("stream1", bus_s.dn_payload_o, 64'h2);
      chk("stream1.occ", PW'(bus_s.occupancy_o), 64'd1);
      cyc(1, 30'h13, 64'h3, 0, 0, 1); tick;
      chk("stream2", bus_s.dn_payload_o, 64'h3);
      chk("stream2.ready", PW'(bus_s.up_ready_o), 64'd1);
      cyc(0, 0, 0, 0, 0, 1); tick;
      chk("stream.drain", PW'(bus_s.dn_valid_o), 64'd0);

      // back-pressure
      cyc(1, 30'h20, 64'hA, 0, 0, 0); tick;
      cyc(1, 30'h21, 64'hB, 0, 0, 0); tick;
      chk("bp.occ2", PW'(bus_s.occupancy_o), 64'd2);
      chk("bp.ready0", PW'(bus_s.up_ready_o), 64'd0);
      chk("bp.headA", bus_s.dn_payload_o, 64'hA);
      cyc(1, 30'h22, 64'hC, 0, 0, 0); tick;
      chk("bp.holdA", bus_s.dn_payload_o, 64'hA);
      cyc(1, 30'h22, 64'hC, 0, 0, 1); tick;
      chk("bp.headB", bus_s.dn_payload_o, 64'hB);
      cyc(1, 30'h22, 64'hC, 0, 0, 1); tick;
      chk("bp.headC", bus_s.dn_payload_o, 64'hC);
      cyc(0, 0, 0, 0, 0, 1); tick;
      chk("bp.drain", PW'(bus_s.occupancy_o), 64'd0);

      // kill
      cyc(0, 30'h3FF, 64'h55, 1, 0, 0); tick;
      chk("kill.noaccept", PW'(bus_s.dn_valid_o), 64'd0);
      cyc(1, 30'h100, 64'hDEAD, 1, 0, 0); tick;
      chk("kill.side", PW'(bus_s.dn_side_o), 64'h100);
      chk("kill.payload", bus_s.dn_payload_o, NOP);
      chk("kill.flag", PW'(bus_s.dn_killed_o), 64'd1);
      chk("kill.valid", PW'(bus_s.dn_valid_o), 64'd1);
      cyc(1, 30'h104, 64'h77, 0, 0, 1); tick;
      chk("kill.next_flag", PW'(bus_s.dn_killed_o), 64'd0);
      chk("kill.next_payload", bus_s.dn_payload_o, 64'h77);
      cyc(0, 0, 0, 0, 0, 1); tick;

      // flush while full
      cyc(1, 30'h40, 64'h41, 0, 0, 0);
      cyc(1, 30'h42, 64'h43, 0, 0, 0); tick;
      chk("flush.pre_occ", PW'(bus_s.occupancy_o), 64'd2);
      cyc(1, 30'h99, 64'h99, 0, 1, 1); tick;
      chk_reset_vals("flush");
      chk("flush.s_ready", PW'(bus_s.up_ready_o), 64'd1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);

      // reset mid-operation
      cyc(1, 30'h50, 64'h51, 0, 0, 0);
      cyc(1, 30'h52, 64'h53, 0, 0, 0); tick;
      chk("rst.pre_occ", PW'(bus_s.occupancy_o), 64'd2);
      #1;
      rst_n = 1'b0; up_valid = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      #6 rst_n = 1'b1;
      cyc(1, 30'h5, 64'h5, 0, 0, 1); tick;
      chk("rst.after_beat", bus_s.dn_payload_o, 64'h5);
      chk("rst.after_occ", PW'(bus_s.occupancy_o), 64'd1);
      cyc(0, 0, 0, 0, 0, 1); tick;
      chk("rst.after_drain", PW'(bus_s.dn_valid_o), 64'd0);

      // single-entry combinational ready
      cyc(1, 30'h31, 64'h31, 0, 0, 0); tick;
      chk("single.valid", PW'(bus_n.dn_valid_o), 64'd1);
      chk("single.ready0", PW'(bus_n.up_ready_o), 64'd0);
      cyc(1, 30'h32, 64'h32, 0, 0, 1);
      #1;
      chk("single.ready1", PW'(bus_n.up_ready_o), 64'd1);
      tick;
      chk("single.passthru", bus_n.dn_payload_o, 64'h32);
      chk("single.occ", PW'(bus_n.occupancy_o), 64'd1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      tick;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised pipeline-stage register replacing fixed stall/flush stage registers (EXE->MEM, MEM->WB and similar).
- Adds a valid/ready handshake with an optional 2-entry skid buffer, so back-pressure is registered and not chained through stages.
- Carries a generic payload plus a side field (PC-like) that survives a kill.
- Supports synchronous flush and per-beat kill (payload forced to NOP, side field kept).

Parameters:
PAYLOAD_WIDTH, 64, width of payload (ctrl op, dst addr, wre, exp code, data, concatenated by the parent)
SIDE_WIDTH, 30, width of side field kept on kill (PC)
NOP_VALUE, {PAYLOAD_WIDTH{1'b0}}, payload value loaded on reset, flush and kill
SKID_EN, 1, 1 = 2-entry skid with registered up_ready_o; 0 = single entry with combinational ready

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous flush, highest priority
kill_i  in  1  qualifies the beat accepted this cycle as killed
up_valid_i  in  1  upstream beat valid
up_ready_o  out  1  stage can accept a beat
up_side_i  in  SIDE_WIDTH  upstream side field
up_payload_i  in  PAYLOAD_WIDTH  upstream payload
dn_valid_o  out  1  downstream beat valid
dn_ready_i  in  1  downstream accepts
dn_side_o  out  SIDE_WIDTH  side field of head entry
dn_payload_o  out  PAYLOAD_WIDTH  payload of head entry
dn_killed_o  out  1  head entry was killed
occupancy_o  out  2  entries held (0..2; max 1 when SKID_EN=0)

Behaviour:
- Reset (async, any time, including mid-transfer): state EMPTY; dn_valid_o=0, dn_side_o=0, dn_payload_o=NOP_VALUE, dn_killed_o=0, occupancy_o=0. up_ready_o=1 once rst_n_i deasserts. Skid entry cleared.
- Accept: up_valid_i & up_ready_o at a rising edge. Pop: dn_valid_o & dn_ready_i at a rising edge.
- Latency: an accepted beat appears on dn_* the next cycle when the stage is empty or popping. Beats leave in arrival order; none dropped or duplicated.
- SKID_EN=1, states EMPTY/ONE/TWO. Head = main register; second = skid register.
  - EMPTY: accept -> ONE.
  - ONE: accept & !pop -> TWO (beat into skid). Accept & pop -> ONE (beat into main). Pop & !accept -> EMPTY.
  - TWO: pop -> ONE (skid moves to main).
  - up_ready_o is a flop: 1 in EMPTY/ONE, 0 in TWO. No combinational path from dn_ready_i to up_ready_o.
- SKID_EN=0: single entry. up_ready_o = !dn_valid_o | dn_ready_i (combinational). Skid logic is not generated.
- Kill: an accepted beat with kill_i=1 stores side = up_side_i, payload = NOP_VALUE, killed = 1. It still occupies a slot and is still presented with dn_valid_o=1. kill_i has no effect without accept.
- Flush: at the edge, both entries are discarded and the stage goes to EMPTY, with outputs at reset values. A beat offered in the same cycle is not stored, even if up_ready_o=1 and the upstream counts it as accepted. Flush overrides pop, accept and kill in the same cycle. up_ready_o=1 the following cycle.
- Hold: with dn_valid_o=1 & dn_ready_i=0, dn_* stay stable every cycle until popped or flushed.
- occupancy_o is registered and matches state: EMPTY=0, ONE=1, TWO=2.

Test Plan:
- Streaming: SKID_EN=1, dn_ready_i=1, beats payload 0x1,0x2,0x3 on consecutive cycles -> dn_payload_o 0x1,0x2,0x3 one cycle later each; occupancy_o=1 throughout; up_ready_o=1.
- Back-pressure: dn_ready_i=0, offer 0xA,0xB,0xC -> 0xA,0xB accepted, occupancy_o=2, up_ready_o=0, 0xC held upstream. Raise dn_ready_i -> outputs 0xA,0xB,0xC in order, no loss.
- Kill: accept side=0x100, payload=0xDEAD with kill_i=1 -> dn_side_o=0x100, dn_payload_o=NOP_VALUE, dn_killed_o=1, dn_valid_o=1. Next unkilled beat -> dn_killed_o=0.
- Flush while full: TWO, then flush_i=1 with up_valid_i=1 and dn_ready_i=1 -> next cycle dn_valid_o=0, occupancy_o=0, payload NOP_VALUE, up_ready_o=1; the offered beat never appears.
- Reset mid-operation: in TWO, pulse rst_n_i low between clock edges -> outputs go to reset values immediately, without waiting for a clock edge; after release, a single beat 0x5 passes normally.
- SKID_EN=0: dn_ready_i=0 with a valid head -> up_ready_o=0 in the same cycle. dn_ready_i=1 with up_valid_i=1 -> pop and accept in one cycle; occupancy_o never exceeds 1.
